// File: rtl/imem_boot_loader.sv
// Instruction-RAM port owner: CPU fetch in RUN, little-endian byte-stream program loader otherwise.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
`timescale 1ns/1ps
module imem_boot_loader #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic [31:0]       pc,
   output logic [31:0]       instr,
   output logic              cpu_hold,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              done,
   output logic              err
);

   localparam logic [31:0]      NOP   = 32'hE1A00000;
   localparam int unsigned      LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

   typedef enum logic [2:0] {
      S_RUN,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_CSUM
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_widx;
   logic [LEN_W-1:0]    r_len;
   logic [1:0]          r_bcnt;
   logic [23:0]         r_word;
   logic                r_byte_ready;
   logic                r_cpu_hold;
   logic                r_we;
   logic [31:0]         r_wdata;
   logic                r_done;
   logic                r_err;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]          r_csum;
`endif

   logic                w_xfer;
   logic                w_len_ok;
   logic                w_last;
   logic                w_run;
   logic                w_unused_pc;

   assign w_xfer      = byte_valid & r_byte_ready;
   assign w_len_ok    = (byte_data != 8'd0) && (9'(byte_data) <= 9'(DEPTH));
   assign w_last      = ({1'b0, r_widx} == (r_len - ONE_L));
   assign w_run       = (r_state == S_RUN);
   // Fetch uses only the word-address bits; the rest of pc wraps modulo DEPTH.
   assign w_unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

   assign ram_addr   = w_run ? pc[ADDR_W+1:2] : r_widx;
   assign instr      = w_run ? ram_rdata : NOP;
   assign byte_ready = r_byte_ready;
   assign cpu_hold   = r_cpu_hold;
   assign ram_we     = r_we;
   assign ram_wdata  = r_wdata;
   assign done       = r_done;
   assign err        = r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_RUN;
         r_widx       <= '0;
         r_len        <= '0;
         r_bcnt       <= '0;
         r_word       <= '0;
         r_byte_ready <= 1'b0;
         r_cpu_hold   <= 1'b0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
         r_csum       <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         r_we   <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (load_start) begin
                  r_state      <= S_LEN;
                  r_err        <= 1'b0;
                  r_byte_ready <= 1'b1;
                  r_cpu_hold   <= 1'b1;
                  r_widx       <= '0;
                  r_bcnt       <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                  r_csum       <= '0;
`endif
               end
            end
            S_LEN: begin
               if (w_xfer) begin
                  if (w_len_ok) begin
                     r_len   <= LEN_W'(byte_data);
                     r_state <= S_DATA;
                  end else begin
                     r_err        <= 1'b1;
                     r_state      <= S_RUN;
                     r_byte_ready <= 1'b0;
                     r_cpu_hold   <= 1'b0;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                  r_csum <= r_csum ^ byte_data;
`endif
                  case (r_bcnt)
                     2'd0: r_word[7:0]   <= byte_data;
                     2'd1: r_word[15:8]  <= byte_data;
                     2'd2: r_word[23:16] <= byte_data;
                     default: begin
                        r_wdata      <= {byte_data, r_word};
                        r_we         <= 1'b1;
                        r_byte_ready <= 1'b0;
                        r_state      <= S_WRITE;
                     end
                  endcase
               end
            end
            S_WRITE: begin
               r_widx <= r_widx + 1'b1;
               if (w_last) begin
`ifdef IMEM_LOADER_CSUM_EN
                  r_state      <= S_CSUM;
                  r_byte_ready <= 1'b1;
`else
                  r_state      <= S_RUN;
                  r_cpu_hold   <= 1'b0;
                  r_done       <= 1'b1;
`endif
               end else begin
                  r_state      <= S_DATA;
                  r_byte_ready <= 1'b1;
               end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
               if (w_xfer) begin
                  r_state      <= S_RUN;
                  r_byte_ready <= 1'b0;
                  r_cpu_hold   <= 1'b0;
                  if (byte_data == r_csum) r_done <= 1'b1;
                  else                     r_err  <= 1'b1;
               end
            end
`endif
            default: begin
               r_state      <= S_RUN;
               r_byte_ready <= 1'b0;
               r_cpu_hold   <= 1'b0;
            end
         endcase
      end
   end

endmodule
